// File: rtl/reg_file_param_pkg.sv
// Shared constants and types for the register file and its dump engine.
// Default widths are also used by the ALU and memory blocks.
package reg_file_param_pkg;

    localparam int INIT_ZERO  = 0;
    localparam int INIT_INDEX = 1;

    localparam int DEFAULT_DATA_W   = 12;
    localparam int DEFAULT_NUM_REGS = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } dump_state_e;

endpackage

// File: rtl/reg_file_param_dump_fsm.sv
// Dump engine: walks register indices 0..NUM_REGS-1 with a ready/valid
// handshake, then pulses dump_done for one cycle.
module regfile_dump_fsm
    import reg_file_param_pkg::*;
#(
    parameter int NUM_REGS = DEFAULT_NUM_REGS,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              dump_start,
    input  logic              dump_ready,
    output logic              dump_valid,
    output logic              dump_busy,
    output logic              dump_done,
    output logic [ADDR_W-1:0] dump_index
);

    localparam logic [ADDR_W-1:0] LAST_INDEX = ADDR_W'(NUM_REGS - 1);

    dump_state_e       state_q, state_d;
    logic [ADDR_W-1:0] index_q, index_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            index_q <= '0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        index_d    = index_q;
        dump_valid = 1'b0;
        dump_busy  = 1'b0;
        dump_done  = 1'b0;
        case (state_q)
            IDLE: begin
                if (dump_start) begin
                    state_d = SCAN;
                    index_d = '0;
                end
            end
            SCAN: begin
                dump_valid = 1'b1;
                dump_busy  = 1'b1;
                if (dump_ready) begin
                    if (index_q == LAST_INDEX) begin
                        // Park the index at 0 so IDLE presents index 0.
                        state_d = DONE;
                        index_d = '0;
                    end else begin
                        index_d = index_q + 1'b1;
                    end
                end
            end
            DONE: begin
                dump_done = 1'b1;
                dump_busy = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
                index_d = '0;
            end
        endcase
    end

    assign dump_index = index_q;

endmodule

// File: rtl/reg_file_param.sv
// Parametrised register file: two combinational read ports with write bypass,
// one synchronous write port, optional hardwired zero register and a dump engine.
module reg_file_param
    import reg_file_param_pkg::*;
#(
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter int NUM_REGS  = DEFAULT_NUM_REGS,
    parameter int ADDR_W    = $clog2(NUM_REGS),
    parameter int INIT_MODE = INIT_INDEX,
    parameter int ZERO_REG  = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    input  logic [ADDR_W-1:0] rd,
    input  logic              RegWrite,
    input  logic [DATA_W-1:0] Writedata,
    output logic [DATA_W-1:0] data1,
    output logic [DATA_W-1:0] data2,
    input  logic              dump_start,
    input  logic              dump_ready,
    output logic              dump_valid,
    output logic [ADDR_W-1:0] dump_index,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_busy,
    output logic              dump_done
);

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic              write_ok;

    assign write_ok = RegWrite && !((ZERO_REG != 0) && (rd == '0));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if ((INIT_MODE == INIT_INDEX) && !((ZERO_REG != 0) && (i == 0)))
                    regs[i] <= DATA_W'(i);
                else
                    regs[i] <= '0;
            end
        end else if (write_ok) begin
            regs[rd] <= Writedata;
        end
    end

    always_comb begin
        data1 = regs[rs1];
        if ((ZERO_REG != 0) && (rs1 == '0))
            data1 = '0;
        else if (write_ok && (rd == rs1))
            data1 = Writedata;
    end

    always_comb begin
        data2 = regs[rs2];
        if ((ZERO_REG != 0) && (rs2 == '0))
            data2 = '0;
        else if (write_ok && (rd == rs2))
            data2 = Writedata;
    end

    regfile_dump_fsm #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_dump_fsm (
        .clock      (clock),
        .reset      (reset),
        .dump_start (dump_start),
        .dump_ready (dump_ready),
        .dump_valid (dump_valid),
        .dump_busy  (dump_busy),
        .dump_done  (dump_done),
        .dump_index (dump_index)
    );

    // Dump shows committed contents only; a same-cycle write appears next cycle.
    assign dump_data = dump_valid ? regs[dump_index] : '0;

endmodule
